mem_access_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the MEM/WB register. It drives the data-memory request/acknowledge handshake for loads and stores and holds the pipeline with `stall` until the memory acknowledges. While stalled it turns the instruction into a bubble towards MEM/WB. It also keeps saturating performance counters and a misalignment flag.

---
 rtl/mem_access_if.sv | 27 ++
 rtl/mem_access_stage.sv | 104 ++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/acknowledge bus between the MEM stage and data memory
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: dmem handshake, stall, counters; optional watchdog via MEM_ACCESS_TIMEOUT_EN
module mem_access_stage #(
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mwreg,
    input  logic         mm2reg,
    input  logic         mwmem,
    input  logic [31:0]  maluout,
    input  logic [31:0]  mb,
    output logic         mwreg_out,
    output logic [31:0]  data_out,
    output logic         stall,
    output logic         misalign,
    output logic         timeout_err,
    output logic [15:0]  acc_cnt,
    output logic [15:0]  stall_cnt,
    mem_access_if.master mem
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t state;
    logic   acc;
    logic   req;
    logic   forced;

    // A load+store combination is treated as a store (dmem_we follows mwmem).
    assign acc = mm2reg | mwmem;
    assign req = ((state == IDLE) && acc) || (state == WAIT);

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [3:0] wait_cnt;

    // Expiry fires in the WAIT cycle where the count would reach TIMEOUT; a real ack in that cycle wins.
    assign forced = (state == WAIT) && !mem.dmem_ack && (wait_cnt == TIMEOUT - 4'd1);

    // Watchdog counter: cleared when a request starts waiting, counts every WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if ((state == IDLE) && acc && !mem.dmem_ack) begin
            wait_cnt <= 4'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Sticky record that some access was abandoned by the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (forced) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign forced = 1'b0;
    // TIMEOUT only matters for the watchdog build; the flag is tied low here.
    assign timeout_err = 1'b0 & (TIMEOUT != 4'd0);
`endif

    assign mem.dmem_req   = req;
    assign mem.dmem_we    = req & mwmem;
    assign mem.dmem_addr  = maluout[31:2];
    assign mem.dmem_wdata = mb;

    // A forced completion releases the pipeline without an ack and delivers zero data.
    assign stall     = req & ~mem.dmem_ack & ~forced;
    assign mwreg_out = mwreg & ~stall;
    assign data_out  = (mm2reg && !forced) ? mem.dmem_rdata : 32'h0;

    // Handshake FSM: zero-wait acks never leave IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (acc && !mem.dmem_ack) state <= WAIT;
                WAIT:    if (mem.dmem_ack || forced) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating performance counters and the sticky misalignment flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt   <= 16'h0;
            stall_cnt <= 16'h0;
            misalign  <= 1'b0;
        end else begin
            if (req && mem.dmem_ack && (acc_cnt != 16'hFFFF)) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (req && (maluout[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mwreg = 1'b0;
    logic        mm2reg = 1'b0;
    logic        mwmem = 1'b0;
    logic [31:0] maluout = 32'h0;
    logic [31:0] mb = 32'h0;
    logic        mwreg_out;
    logic [31:0] data_out;
    logic        stall;
    logic        misalign;
    logic        timeout_err;
    logic [15:0] acc_cnt;
    logic [15:0] stall_cnt;

    mem_access_if mem_bus ();

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_acc = 0;
    int   exp_stl = 0;
    logic exp_mis = 1'b0;

    mem_access_stage dut (
        .clk         (clk),
        .rst         (rst),
        .mwreg       (mwreg),
        .mm2reg      (mm2reg),
        .mwmem       (mwmem),
        .maluout     (maluout),
        .mb          (mb),
        .mwreg_out   (mwreg_out),
        .data_out    (data_out),
        .stall       (stall),
        .misalign    (misalign),
        .timeout_err (timeout_err),
        .acc_cnt     (acc_cnt),
        .stall_cnt   (stall_cnt),
        .mem         (mem_bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // One memory transaction; called at posedge+1, returns at posedge+1 after the completion edge.
    task automatic do_access(input logic ld, input logic st, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int lat, input string tag);
        logic [31:0] exp_data;
        mm2reg = ld; mwmem = st; mwreg = wr; maluout = addr; mb = wd;
        exp_data = ld ? rd : 32'h0;
        for (int cyc = 0; cyc <= lat; cyc++) begin
            mem_bus.dmem_ack   = (cyc == lat);
            mem_bus.dmem_rdata = (cyc == lat) ? rd : $urandom;
            @(negedge clk);
            n_cmp++;
            if (mem_bus.dmem_req !== 1'b1 || mem_bus.dmem_we !== st ||
                mem_bus.dmem_addr !== addr[31:2] || mem_bus.dmem_wdata !== wd) begin
                n_err++;
                $display("FAIL %s bus cyc=%0d: req=%b we=%b addr=%h wdata=%h, required 1 %b %h %h",
                         tag, cyc, mem_bus.dmem_req, mem_bus.dmem_we, mem_bus.dmem_addr,
                         mem_bus.dmem_wdata, st, addr[31:2], wd);
            end
            n_cmp++;
            if (stall !== (cyc < lat) || mwreg_out !== (wr && cyc == lat)) begin
                n_err++;
                $display("FAIL %s stall cyc=%0d: stall=%b mwreg_out=%b, required %b %b",
                         tag, cyc, stall, mwreg_out, (cyc < lat), (wr && cyc == lat));
            end
            if (cyc == lat) begin
                n_cmp++;
                if (data_out !== exp_data) begin
                    n_err++;
                    $display("FAIL %s data_out: got %h, required %h", tag, data_out, exp_data);
                end
            end
            @(posedge clk);
            if (cyc < lat) exp_stl = sat(exp_stl);
            #1;
        end
        exp_acc = sat(exp_acc);
        if (addr[1:0] != 2'b00) exp_mis = 1'b1;
        mem_bus.dmem_ack = 1'b0;
        n_cmp++;
        if (acc_cnt !== 16'(exp_acc) || stall_cnt !== 16'(exp_stl) || misalign !== exp_mis) begin
            n_err++;
            $display("FAIL %s counters: acc=%0d stall=%0d mis=%b, required %0d %0d %b",
                     tag, acc_cnt, stall_cnt, misalign, exp_acc, exp_stl, exp_mis);
        end
    endtask

    task automatic idle_cycles(input int n);
        mm2reg = 1'b0; mwmem = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #1;
        rst = 1'b1;
        #2;
        n_cmp++;
        if (acc_cnt !== 16'h0 || stall_cnt !== 16'h0 || misalign !== 1'b0 || timeout_err !== 1'b0 ||
            mem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset: acc=%h stall_cnt=%h mis=%b tout=%b req=%b stall=%b, required all 0",
                     acc_cnt, stall_cnt, misalign, timeout_err, mem_bus.dmem_req, stall);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_acc = 0; exp_stl = 0; exp_mis = 1'b0;
    endtask

    task automatic test_load_zero_wait;
        do_access(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0, "load0");
        n_cmp++;
        if (acc_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL load0_cnt: acc=%0d stall=%0d, required 1 0", acc_cnt, stall_cnt);
        end
    endtask

    task automatic test_store_wait;
        do_access(1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 32'h0, 3, "store3");
        n_cmp++;
        if (stall_cnt !== 16'd3 || acc_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL store3_cnt: stall=%0d acc=%0d, required 3 2", stall_cnt, acc_cnt);
        end
    endtask

    task automatic test_passthrough;
        for (int i = 0; i < 4; i++) begin
            mm2reg = 1'b0; mwmem = 1'b0;
            mwreg = 1'($urandom);
            maluout = $urandom;
            mem_bus.dmem_ack = 1'b1;
            mem_bus.dmem_rdata = $urandom;
            @(negedge clk);
            n_cmp++;
            if (mem_bus.dmem_req !== 1'b0 || stall !== 1'b0 || mwreg_out !== mwreg || data_out !== 32'h0) begin
                n_err++;
                $display("FAIL passthru: req=%b stall=%b mwreg_out=%b data=%h, required 0 0 %b 0",
                         mem_bus.dmem_req, stall, mwreg_out, data_out, mwreg);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (acc_cnt !== 16'(exp_acc) || stall_cnt !== 16'(exp_stl) || misalign !== exp_mis) begin
                n_err++;
                $display("FAIL passthru_cnt: acc=%0d stall=%0d mis=%b, required %0d %0d %b",
                         acc_cnt, stall_cnt, misalign, exp_acc, exp_stl, exp_mis);
            end
        end
        mem_bus.dmem_ack = 1'b0;
    endtask

    task automatic test_misalign;
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_pre: got %b, required 0", misalign);
        end
        do_access(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, $urandom, 1, "mis_load");
        do_access(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, $urandom, 0, "aligned1");
        do_access(1'b0, 1'b1, 1'b0, 32'h304, $urandom, 32'h0, 2, "aligned2");
        n_cmp++;
        if (misalign !== 1'b1) begin
            n_err++;
            $display("FAIL misalign_sticky: got %b, required 1", misalign);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            do_access(kind != 1, kind != 0, 1'($urandom), $urandom, $urandom, $urandom,
                      $urandom_range(0, 8), "b2b");
        end
        idle_cycles(2);
    endtask

    task automatic test_watchdog;
`ifdef MEM_ACCESS_TIMEOUT_EN
        int bad;
        int acc_before;
        bad = 0;
        acc_before = exp_acc;
        mm2reg = 1'b1; mwmem = 1'b0; mwreg = 1'b1; maluout = 32'h400;
        mem_bus.dmem_ack = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (stall !== 1'b1) bad++;
            @(posedge clk);
            exp_stl = sat(exp_stl);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (bad != 0 || stall !== 1'b0 || data_out !== 32'h0) begin
            n_err++;
            $display("FAIL watchdog_stall: missing=%0d stall=%b data=%h, required 0 0 0", bad, stall, data_out);
        end
        @(posedge clk);
        #1;
        mm2reg = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b1 || acc_cnt !== 16'(acc_before) || stall_cnt !== 16'(exp_stl)) begin
            n_err++;
            $display("FAIL watchdog_flag: tout=%b acc=%0d stall=%0d, required 1 %0d %0d",
                     timeout_err, acc_cnt, stall_cnt, acc_before, exp_stl);
        end
`else
        do_access(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, $urandom, 30, "long_wait");
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL no_watchdog: timeout_err=%b, required 0", timeout_err);
        end
`endif
        idle_cycles(1);
    endtask

    task automatic test_reset_in_wait;
        mm2reg = 1'b1; mwmem = 1'b0; mwreg = 1'b1; maluout = 32'h104;
        mem_bus.dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (acc_cnt !== 16'h0 || stall_cnt !== 16'h0 || misalign !== 1'b0 || timeout_err !== 1'b0 ||
            mem_bus.dmem_req !== 1'b1 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait_acc1: acc=%h stall_cnt=%h mis=%b tout=%b req=%b stall=%b, required 0 0 0 0 1 1",
                     acc_cnt, stall_cnt, misalign, timeout_err, mem_bus.dmem_req, stall);
        end
        mm2reg = 1'b0;
        #2;
        n_cmp++;
        if (mem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait_acc0: req=%b stall=%b, required 0 0", mem_bus.dmem_req, stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_acc = 0; exp_stl = 0; exp_mis = 1'b0;
        do_access(1'b1, 1'b0, 1'b1, 32'h108, 32'h0, $urandom, 0, "post_rst");
    endtask

    task automatic test_stall_saturation;
        int edges_to_fffe;
        int total_edges;
        rst = 1'b1; #1; rst = 1'b0;
        exp_acc = 0; exp_stl = 0; exp_mis = 1'b0;
        mm2reg = 1'b1; mwmem = 1'b0; mwreg = 1'b0; maluout = 32'h500;
        mem_bus.dmem_ack = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        edges_to_fffe = 4368 * 16 + 14;
        total_edges   = 4370 * 16;
`else
        edges_to_fffe = 65534;
        total_edges   = 65540;
`endif
        for (int i = 0; i < edges_to_fffe; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_cnt !== 16'hFFFE) begin
            n_err++;
            $display("FAIL sat_fffe: stall_cnt=%h, required fffe", stall_cnt);
        end
        for (int i = edges_to_fffe; i < total_edges; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_cnt !== 16'hFFFF || acc_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL sat_hold: stall_cnt=%h acc=%h, required ffff 0", stall_cnt, acc_cnt);
        end
        exp_stl = 65535;
        idle_cycles(1);
        do_access(1'b1, 1'b0, 1'b1, 32'h600, 32'h0, $urandom, 2, "post_sat");
    endtask

    initial begin
        mem_bus.dmem_ack = 1'b0;
        mem_bus.dmem_rdata = 32'h0;
        test_reset;
        test_load_zero_wait;
        test_store_wait;
        test_passthrough;
        test_misalign;
        test_back_to_back;
        test_watchdog;
        test_reset_in_wait;
        test_stall_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
